// File: rtl/apb_fabric_rr.sv
// apb_fabric_rr: APB3/APB4 interconnect joining MST masters to SLV slaves over one
// shared routed path. Round-robin arbitration, mask/base decode, an error response on
// decode miss, and an optional watchdog that ends hung slave transfers with PSLVERR.

package apb_fabric_rr_pkg;
  // Default bases: slave s lives at s<<12, slaves packed low-first.
  function automatic logic [4095:0] dflt_base(input int slv, input int addr);
    logic [4095:0] v;
    v = '0;
    for (int s = 0; s < slv; s++) v = v | (4096'(s) << (12 + s * addr));
    return v;
  endfunction

  // Default masks: each slave decodes every address bit above bit 11.
  function automatic logic [4095:0] dflt_mask(input int slv, input int addr);
    logic [4095:0] v;
    logic [4095:0] m;
    v = '0;
    m = ((4096'(1) << addr) - 4096'(1)) ^ 4096'('hFFF);
    for (int s = 0; s < slv; s++) v = v | (m << (s * addr));
    return v;
  endfunction
endpackage

module apb_fabric_rr #(
  parameter int MST  = 2,
  parameter int SLV  = 4,
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter logic [SLV-1:0][ADDR-1:0] SLV_BASE = (SLV*ADDR)'(apb_fabric_rr_pkg::dflt_base(SLV, ADDR)),
  parameter logic [SLV-1:0][ADDR-1:0] SLV_MASK = (SLV*ADDR)'(apb_fabric_rr_pkg::dflt_mask(SLV, ADDR)),
  parameter int TIMEOUT = 16
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic [MST-1:0]               mst_psel,
  input  logic [MST-1:0]               mst_penable,
  input  logic [MST-1:0][2:0]          mst_pprot,
  input  logic [MST-1:0][ADDR-1:0]     mst_paddr,
  input  logic [MST-1:0]               mst_pwrite,
  input  logic [MST-1:0][DATA/8-1:0]   mst_pstrb,
  input  logic [MST-1:0][DATA-1:0]     mst_pwdata,
  output logic [MST-1:0][DATA-1:0]     mst_prdata,
  output logic [MST-1:0]               mst_pslverr,
  output logic [MST-1:0]               mst_pready,
  output logic [SLV-1:0]               slv_psel,
  output logic [SLV-1:0]               slv_penable,
  output logic [SLV-1:0][2:0]          slv_pprot,
  output logic [SLV-1:0][ADDR-1:0]     slv_paddr,
  output logic [SLV-1:0]               slv_pwrite,
  output logic [SLV-1:0][DATA/8-1:0]   slv_pstrb,
  output logic [SLV-1:0][DATA-1:0]     slv_pwdata,
  input  logic [SLV-1:0][DATA-1:0]     slv_prdata,
  input  logic [SLV-1:0]               slv_pslverr,
  input  logic [SLV-1:0]               slv_pready
);
  localparam int STB = DATA / 8;
  localparam int MW  = (MST > 1) ? $clog2(MST) : 1;
  localparam int SW  = (SLV > 1) ? $clog2(SLV) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_t;

  state_t          r_state;
  logic [MW-1:0]   r_ptr;
  logic [MW-1:0]   r_gnt;
  logic [SW-1:0]   r_slv;
  logic [ADDR-1:0] r_addr;
  logic            r_write;
  logic [DATA-1:0] r_wdata;
  logic [STB-1:0]  r_strb;
  logic [2:0]      r_prot;
  logic [TW-1:0]   r_wdog;

  logic            w_req_any;
  logic [MW-1:0]   w_gnt;
  logic [ADDR-1:0] w_addr;
  logic            w_hit;
  logic [SW-1:0]   w_slv;
  logic            w_done;
  logic            w_tmo;
  logic            w_errdone;

  assign w_req_any = |mst_psel;
  assign w_addr    = mst_paddr[w_gnt];

  // Round-robin pick: scan downward so the requester nearest the pointer overwrites last.
  always_comb begin
    int idx;
    idx   = 0;
    w_gnt = '0;
    for (int k = MST - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % MST;
      if (mst_psel[MW'(idx)]) w_gnt = MW'(idx);
    end
  end

  // Address decode of the granted master; scanning downward lets the lowest slave win.
  always_comb begin
    w_hit = 1'b0;
    w_slv = '0;
    for (int s = SLV - 1; s >= 0; s--) begin
      if ((w_addr & SLV_MASK[s]) == SLV_BASE[s]) begin
        w_hit = 1'b1;
        w_slv = SW'(s);
      end
    end
  end

  assign w_done    = (r_state == S_ACCESS) && slv_pready[r_slv] && mst_penable[r_gnt];
  assign w_tmo     = (TIMEOUT != 0) && (r_state == S_ACCESS) && (int'(r_wdog) == TIMEOUT - 1);
  assign w_errdone = (r_state == S_ERR) && mst_penable[r_gnt];

  // Transfer FSM: grant and capture in IDLE, then SETUP/ACCESS to the slave or ERR on miss.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_slv   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_prot  <= '0;
      r_wdog  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_gnt   <= w_gnt;
            r_ptr   <= (int'(w_gnt) == MST - 1) ? '0 : w_gnt + 1'b1;
            r_addr  <= w_addr;
            r_write <= mst_pwrite[w_gnt];
            r_wdata <= mst_pwdata[w_gnt];
            r_strb  <= mst_pstrb[w_gnt];
            r_prot  <= mst_pprot[w_gnt];
            r_slv   <= w_slv;
            r_wdog  <= '0;
            r_state <= w_hit ? S_SETUP : S_ERR;
          end
        end
        S_SETUP: begin
          r_wdog  <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          // A ready slave on the watchdog's last cycle still completes normally.
          if (w_done || w_tmo) r_state <= S_IDLE;
          else                 r_wdog  <= r_wdog + 1'b1;
        end
        S_ERR: begin
          if (mst_penable[r_gnt]) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Master-side response is combinational so completion lands in the slave's ready cycle.
  always_comb begin
    mst_pready  = '0;
    mst_pslverr = '0;
    mst_prdata  = '0;
    if (!preset) begin
      if (w_done) begin
        mst_pready[r_gnt]  = 1'b1;
        mst_pslverr[r_gnt] = slv_pslverr[r_slv];
        mst_prdata[r_gnt]  = slv_prdata[r_slv];
      end else if (w_tmo || w_errdone) begin
        mst_pready[r_gnt]  = 1'b1;
        mst_pslverr[r_gnt] = 1'b1;
      end
    end
  end

  // Slave-side bus: only the decoded slave sees the captured fields, all others idle at 0.
  always_comb begin
    slv_psel    = '0;
    slv_penable = '0;
    slv_pprot   = '0;
    slv_paddr   = '0;
    slv_pwrite  = '0;
    slv_pstrb   = '0;
    slv_pwdata  = '0;
    if (r_state == S_SETUP || r_state == S_ACCESS) begin
      slv_psel[r_slv]    = 1'b1;
      slv_penable[r_slv] = (r_state == S_ACCESS);
      slv_pprot[r_slv]   = r_prot;
      slv_paddr[r_slv]   = r_addr;
      slv_pwrite[r_slv]  = r_write;
      slv_pstrb[r_slv]   = r_strb;
      slv_pwdata[r_slv]  = r_wdata;
    end
  end

endmodule

// File: tb/tb_apb_fabric_rr.sv
// Bench for apb_fabric_rr: a transfer-level model (round-robin over pending masters,
// slave index = addr>>12, completion at max(slave wait, master enable delay) capped by
// the watchdog) predicts every output each cycle; directed cases pin the model.
module tb_apb_fabric_rr;
  localparam int MST = 2, SLV = 4, ADDR = 32, DATA = 32, STB = DATA / 8, TMO = 16;

  logic pclk = 1'b0;
  logic preset;
  logic [MST-1:0]             mst_psel, mst_penable, mst_pwrite, mst_pslverr, mst_pready;
  logic [MST-1:0][2:0]        mst_pprot;
  logic [MST-1:0][ADDR-1:0]   mst_paddr;
  logic [MST-1:0][STB-1:0]    mst_pstrb;
  logic [MST-1:0][DATA-1:0]   mst_pwdata, mst_prdata;
  logic [SLV-1:0]             slv_psel, slv_penable, slv_pwrite, slv_pslverr, slv_pready;
  logic [SLV-1:0][2:0]        slv_pprot;
  logic [SLV-1:0][ADDR-1:0]   slv_paddr;
  logic [SLV-1:0][STB-1:0]    slv_pstrb;
  logic [SLV-1:0][DATA-1:0]   slv_pwdata, slv_prdata;

  apb_fabric_rr #(.MST(MST), .SLV(SLV), .ADDR(ADDR), .DATA(DATA), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .mst_psel(mst_psel), .mst_penable(mst_penable), .mst_pprot(mst_pprot),
    .mst_paddr(mst_paddr), .mst_pwrite(mst_pwrite), .mst_pstrb(mst_pstrb),
    .mst_pwdata(mst_pwdata), .mst_prdata(mst_prdata), .mst_pslverr(mst_pslverr),
    .mst_pready(mst_pready),
    .slv_psel(slv_psel), .slv_penable(slv_penable), .slv_pprot(slv_pprot),
    .slv_paddr(slv_paddr), .slv_pwrite(slv_pwrite), .slv_pstrb(slv_pstrb),
    .slv_pwdata(slv_pwdata), .slv_prdata(slv_prdata), .slv_pslverr(slv_pslverr),
    .slv_pready(slv_pready)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0, n_bad = 0;

  // expected outputs for the current cycle
  logic [MST-1:0]           e_mrdy, e_merr;
  logic [MST-1:0][DATA-1:0] e_mrd;
  logic [SLV-1:0]           e_spsel, e_spen, e_swr;
  logic [SLV-1:0][2:0]      e_spr;
  logic [SLV-1:0][ADDR-1:0] e_sad;
  logic [SLV-1:0][STB-1:0]  e_sst;
  logic [SLV-1:0][DATA-1:0] e_swd;

  // pending master requests
  logic [ADDR-1:0] q_addr[MST];
  logic            q_wr[MST];
  logic [DATA-1:0] q_wd[MST];
  logic [STB-1:0]  q_st[MST];
  logic [2:0]      q_pr[MST];
  bit              act[MST];
  int              age[MST];
  int              m_ptr;

  // current transfer plan
  int c_g, c_s, c_W, c_D, c_tr;
  bit c_hit;
  logic [DATA-1:0] c_rd, c_srd;
  logic c_err, c_serr;

  // directed knobs
  bit f_fix;
  int f_W, f_D, f_abort;
  logic [DATA-1:0] f_rd;
  logic f_err;

  int glog[$], tlog[$], slog[$];
  logic [DATA-1:0] cap_rd, cap_pwd;
  logic cap_err, cap_rdy;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t got %h expected %h", nm, $time, a, e);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".mst_pready"},  128'(mst_pready),  128'(e_mrdy));
    chk({t, ".mst_pslverr"}, 128'(mst_pslverr), 128'(e_merr));
    chk({t, ".mst_prdata"},  128'(mst_prdata),  128'(e_mrd));
    chk({t, ".slv_psel"},    128'(slv_psel),    128'(e_spsel));
    chk({t, ".slv_penable"}, 128'(slv_penable), 128'(e_spen));
    chk({t, ".slv_paddr"},   128'(slv_paddr),   128'(e_sad));
    chk({t, ".slv_pwrite"},  128'(slv_pwrite),  128'(e_swr));
    chk({t, ".slv_pwdata"},  128'(slv_pwdata),  128'(e_swd));
    chk({t, ".slv_pstrb"},   128'(slv_pstrb),   128'(e_sst));
    chk({t, ".slv_pprot"},   128'(slv_pprot),   128'(e_spr));
  endtask

  task automatic drive(input int r);
    for (int m = 0; m < MST; m++) begin
      if (act[m]) begin
        bit pen;
        pen = (age[m] > 0);
        mst_psel[m] = 1'b1;
        if (m == c_g && r >= 1) begin
          // fabric must ignore master fields once granted
          mst_paddr[m]  = $urandom;
          mst_pwdata[m] = $urandom;
          mst_pwrite[m] = 1'($urandom);
          mst_pstrb[m]  = STB'($urandom);
          mst_pprot[m]  = 3'($urandom);
          if (c_hit ? (r >= 2 && r - 2 < c_D) : (r - 1 < c_D)) pen = 1'b0;
        end else begin
          mst_paddr[m]  = q_addr[m];
          mst_pwdata[m] = q_wd[m];
          mst_pwrite[m] = q_wr[m];
          mst_pstrb[m]  = q_st[m];
          mst_pprot[m]  = q_pr[m];
        end
        mst_penable[m] = pen;
      end else begin
        mst_psel[m]    = 1'b0;
        mst_penable[m] = 1'b0;
        mst_paddr[m]   = $urandom;
        mst_pwdata[m]  = $urandom;
        mst_pwrite[m]  = 1'($urandom);
        mst_pstrb[m]   = STB'($urandom);
        mst_pprot[m]   = 3'($urandom);
      end
    end
    for (int s = 0; s < SLV; s++) begin
      slv_pready[s]  = 1'($urandom);
      slv_prdata[s]  = $urandom;
      slv_pslverr[s] = 1'($urandom);
    end
    if (c_g >= 0 && c_hit) begin
      slv_pready[c_s]  = (r >= 2 && r - 2 >= c_W);
      slv_prdata[c_s]  = c_srd;
      slv_pslverr[c_s] = c_serr;
    end
  endtask

  task automatic set_exp(input int r);
    e_mrdy = '0; e_merr = '0; e_mrd = '0;
    e_spsel = '0; e_spen = '0; e_swr = '0; e_spr = '0; e_sad = '0; e_sst = '0; e_swd = '0;
    if (c_g >= 0) begin
      if (c_hit && r >= 1) begin
        e_spsel[c_s] = 1'b1;
        e_spen[c_s]  = (r >= 2);
        e_sad[c_s]   = q_addr[c_g];
        e_swr[c_s]   = q_wr[c_g];
        e_swd[c_s]   = q_wd[c_g];
        e_sst[c_s]   = q_st[c_g];
        e_spr[c_s]   = q_pr[c_g];
      end
      if (r == c_tr) begin
        e_mrdy[c_g] = 1'b1;
        e_merr[c_g] = c_err;
        e_mrd[c_g]  = c_rd;
      end
    end
  endtask

  task automatic cycle(input int r, input bit rst, input bit do_chk);
    @(posedge pclk); #1;
    for (int m = 0; m < MST; m++) if (act[m]) age[m]++;
    preset = rst;
    drive(r);
    set_exp(r);
    @(negedge pclk);
    if (do_chk) check_all($sformatf("g%0d.r%0d", c_g, r));
  endtask

  task automatic idle(input int n);
    c_g = -1;
    repeat (n) cycle(0, 1'b0, 1'b1);
  endtask

  function automatic int pick_w();
    case ($urandom % 10)
      0, 1, 2, 3, 4: return int'($urandom % 4);
      5: return 14;
      6: return 15;
      7: return 16;
      default: return 1000;
    endcase
  endfunction

  task automatic run_xfer();
    int g;
    logic [ADDR-1:0] a;
    g = -1;
    for (int k = 0; k < MST; k++) begin
      int m;
      m = (m_ptr + k) % MST;
      if (g < 0 && act[m]) g = m;
    end
    m_ptr = (g + 1) % MST;
    c_g   = g;
    a     = q_addr[g];
    c_hit = (a >> 12) < SLV;
    c_s   = c_hit ? int'(a >> 12) : -1;
    if (f_fix) begin
      c_W = f_W; c_D = f_D; c_srd = f_rd; c_serr = f_err;
    end else begin
      c_W = pick_w();
      c_D = ($urandom % 4 == 0) ? int'($urandom_range(1, 2)) : 0;
      c_srd = $urandom; c_serr = 1'($urandom);
    end
    if (!c_hit) begin
      c_tr = 1 + c_D; c_err = 1'b1; c_rd = '0;
    end else if (((c_W > c_D) ? c_W : c_D) > TMO - 1) begin
      c_tr = 2 + TMO - 1; c_err = 1'b1; c_rd = '0;
    end else begin
      c_tr = 2 + ((c_W > c_D) ? c_W : c_D); c_err = c_serr; c_rd = c_srd;
    end
    glog.push_back(g); slog.push_back(c_s); tlog.push_back(c_tr);
    for (int r = 0; r <= c_tr; r++) begin
      if (r == f_abort) begin
        cycle(r, 1'b1, 1'b0);
        chk("rst_no_pready", 128'(mst_pready), 128'(0));
        for (int m = 0; m < MST; m++) act[m] = 1'b0;
        m_ptr = 0; f_abort = -1; c_g = -1;
        cycle(0, 1'b0, 1'b1);
        return;
      end
      cycle(r, 1'b0, 1'b1);
      if (r == 1 && c_hit) cap_pwd = slv_pwdata[c_s];
      if (r == c_tr) begin
        cap_rdy = mst_pready[g]; cap_err = mst_pslverr[g]; cap_rd = mst_prdata[g];
      end
    end
    act[g] = 1'b0;
    c_g = -1;
  endtask

  task automatic start_round(input logic [MST-1:0] req);
    bit any;
    for (int m = 0; m < MST; m++) if (req[m]) begin act[m] = 1'b1; age[m] = -1; end
    any = 1'b1;
    while (any) begin
      run_xfer();
      any = 1'b0;
      for (int m = 0; m < MST; m++) if (act[m]) any = 1'b1;
    end
  endtask

  task automatic set_req(input int m, input logic [ADDR-1:0] a, input logic wr, input logic [DATA-1:0] wd);
    q_addr[m] = a; q_wr[m] = wr; q_wd[m] = wd;
    q_st[m] = STB'($urandom); q_pr[m] = 3'($urandom);
  endtask

  initial begin
    preset = 1'b1;
    mst_psel = '0; mst_penable = '0; mst_pwrite = '0; mst_pprot = '0;
    mst_paddr = '0; mst_pstrb = '0; mst_pwdata = '0;
    slv_pready = '0; slv_pslverr = '0; slv_prdata = '0;
    for (int m = 0; m < MST; m++) begin act[m] = 1'b0; age[m] = 0; end
    c_g = -1; m_ptr = 0; f_abort = -1; f_fix = 1'b1;
    f_W = 0; f_D = 0; f_rd = '0; f_err = 1'b0;

    // reset state
    cycle(0, 1'b1, 1'b0);
    cycle(0, 1'b1, 1'b1);

    // both masters twice: grants alternate 0,1,0,1
    repeat (2) begin
      set_req(0, 32'h0000_1000, 1'b1, $urandom);
      set_req(1, 32'h0000_3000, 1'b0, $urandom);
      start_round(2'b11);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr_gnt%0d", i), 128'(glog[i]), 128'(i % 2));
    idle(1);

    // M0 write to slave1, immediate ready: pready at cycle 2
    set_req(0, 32'h0000_1004, 1'b1, 32'hA5A5_A5A5);
    start_round(2'b01);
    chk("t1_lat", 128'(tlog[tlog.size()-1]), 128'(2));
    chk("t1_slv", 128'(slog[slog.size()-1]), 128'(1));
    chk("t1_pwdata", 128'(cap_pwd), 128'(32'hA5A5_A5A5));
    chk("t1_pready", 128'(cap_rdy), 128'(1));
    chk("t1_pslverr", 128'(cap_err), 128'(0));
    idle(1);

    // decode miss
    set_req(0, 32'h0000_9000, 1'b0, $urandom);
    start_round(2'b01);
    chk("miss_lat", 128'(tlog[tlog.size()-1]), 128'(1));
    chk("miss_pready", 128'(cap_rdy), 128'(1));
    chk("miss_pslverr", 128'(cap_err), 128'(1));
    chk("miss_prdata", 128'(cap_rd), 128'(0));

    // hung slave2: watchdog on 16th ACCESS cycle
    f_W = 1000;
    set_req(1, 32'h0000_2000, 1'b0, $urandom);
    start_round(2'b10);
    chk("tmo_lat", 128'(tlog[tlog.size()-1]), 128'(17));
    chk("tmo_pslverr", 128'(cap_err), 128'(1));
    chk("tmo_prdata", 128'(cap_rd), 128'(0));
    idle(2);

    // slave0 read, 3 wait states with error
    f_W = 3; f_rd = 32'h1234_5678; f_err = 1'b1;
    set_req(0, 32'h0000_0000, 1'b0, $urandom);
    start_round(2'b01);
    chk("ws_lat", 128'(tlog[tlog.size()-1]), 128'(5));
    chk("ws_prdata", 128'(cap_rd), 128'(32'h1234_5678));
    chk("ws_pslverr", 128'(cap_err), 128'(1));

    // reset in the middle of ACCESS, then pointer back at M0
    f_W = 1000; f_err = 1'b0; f_abort = 4;
    set_req(0, 32'h0000_2000, 1'b1, $urandom);
    start_round(2'b01);
    f_abort = -1; f_W = 0;
    glog.delete();
    set_req(0, 32'h0000_1000, 1'b1, $urandom);
    set_req(1, 32'h0000_3000, 1'b1, $urandom);
    start_round(2'b11);
    chk("rst_next_gnt", 128'(glog[0]), 128'(0));

    // randomized traffic
    f_fix = 1'b0;
    repeat (200) begin
      for (int m = 0; m < MST; m++) begin
        logic [ADDR-1:0] a;
        if ($urandom % 5 == 0) a = ($urandom_range(SLV, 32'hFFFFF) << 12) | ($urandom & 32'hFFF);
        else                   a = (($urandom % SLV) << 12) | ($urandom & 32'hFFF);
        set_req(m, a, 1'($urandom), $urandom);
      end
      start_round(MST'($urandom_range(1, (1 << MST) - 1)));
      if ($urandom % 3 == 0) idle(1 + int'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
